// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: register file defaults and bus slicing helpers.
package cpu_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

  function automatic int lane_hi(input int idx, input int w);
    return idx * w + w - 1;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered register-file read port with zero masking.
// REGFILE_BYPASS_EN selects write-first forwarding of same-edge writes.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_busy,
  input  logic              post_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic              hit;
  logic              is_zero;
  logic [DATA_W-1:0] d_nxt;
  logic              b_nxt;

  assign hit     = BYPASS && wr_en && (wr_addr == rd_addr);
  assign is_zero = (ZERO_REG != 0) && (rd_addr == ZADDR);

  // Zero masking wins over forwarding.
  always_comb begin
    d_nxt = mem_data;
    b_nxt = BYPASS ? post_busy : mem_busy;
    if (is_zero) begin
      d_nxt = '0;
      b_nxt = 1'b0;
    end else if (hit) begin
      d_nxt = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (rd_en) begin
      rd_data <= d_nxt;
      rd_busy <= b_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard.
// Build option: REGFILE_BYPASS_EN (write-first same-edge reads).
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              set_ok;

  assign wr_ok  = wr_en &&
                  !((ZERO_REG != 0) && (wr_addr == ZADDR));
  assign set_ok = busy_set &&
                  !((ZERO_REG != 0) && (busy_addr == ZADDR));

  // A new producer issued on the retiring register keeps it pending.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wr_addr] = 1'b0;
    if (set_ok)
      busy_nxt[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++)
        mem[j] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok)
        mem[wr_addr] <= wr_data;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[lane_lo(i, ADDR_W) +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en[i]),
      .rd_addr   (a),
      .mem_data  (mem[a]),
      .mem_busy  (busy[a]),
      .post_busy (busy_nxt[a]),
      .wr_en     (wr_ok),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[lane_lo(i, DATA_W) +: DATA_W]),
      .rd_busy   (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: random and directed traffic
// checked against an array model of the register file.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int ZR    = 1;
  localparam int DEPTH = 32;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             busy_set;
  logic [AW-1:0]    busy_addr;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (ZR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          b;
  } exp_t;

  exp_t          sbq[$];
  exp_t          hold[NR];
  logic [DW-1:0] m_mem[DEPTH];
  logic          m_busy[DEPTH];
  logic [NR-1:0] pend;
  int            checks = 0;
  int            errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < DEPTH; j++) begin
      m_mem[j]  = '0;
      m_busy[j] = 1'b0;
    end
    for (int i = 0; i < NR; i++)
      hold[i] = '0;
    sbq.delete();
  endtask

  // One clock of stimulus; expectations are pushed before the edge.
  task automatic cyc(input logic [NR-1:0] en, input logic [NR*AW-1:0] ra,
                     input logic we, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic bs,
                     input logic [AW-1:0] ba);
    logic [DW-1:0] n_mem[DEPTH];
    logic          n_busy[DEPTH];
    logic [AW-1:0] a;
    exp_t          e;
    @(negedge clk);
    rd_en     = en;
    rd_addr   = ra;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    busy_set  = bs;
    busy_addr = ba;
    pend      = en;
    n_mem  = m_mem;
    n_busy = m_busy;
    if (we && !(ZR != 0 && wa == 0)) begin
      n_mem[wa]  = wd;
      n_busy[wa] = 1'b0;
    end
    if (bs && !(ZR != 0 && ba == 0))
      n_busy[ba] = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (en[i]) begin
        a = ra[i*AW +: AW];
        if (ZR != 0 && a == 0)
          e = '{d: '0, b: 1'b0};
        else begin
`ifdef REGFILE_BYPASS_EN
          e = '{d: n_mem[a], b: n_busy[a]};
`else
          e = '{d: m_mem[a], b: m_busy[a]};
`endif
        end
        sbq.push_back(e);
      end
    end
    m_mem  = n_mem;
    m_busy = n_busy;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    cyc(4'b0001, {15'd0, a}, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per enabled port, otherwise checks hold.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty port %0d got none exp entry", i);
          end else begin
            e = sbq.pop_front();
            hold[i] = e;
          end
        end
        chk($sformatf("data%0d", i), lane(i), hold[i].d);
        chk($sformatf("busy%0d", i), {31'd0, rd_busy[i]},
            {31'd0, hold[i].b});
      end
    end
  end

  initial begin
    logic [NR*AW-1:0] ra;
    rst_n = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = 0; wr_addr = '0;
    wr_data = '0; busy_set = 0; busy_addr = '0; pend = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill, then asynchronous reset pulse between edges
    for (int i = 1; i < DEPTH; i++)
      cyc(4'b0000, '0, 1, AW'(i), 32'h1000_0000 | i, i == 4, 5'd4);
    cyc(4'b1111, {5'd4, 5'd3, 5'd2, 5'd31}, 0, 0, 0, 0, 0);
    @(negedge clk);
    rd_en = '0; wr_en = 0; busy_set = 0; pend = '0;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) begin
      chk("rst_data", lane(i), '0);
      chk("rst_busy", {31'd0, rd_busy[i]}, '0);
    end
    #1 rst_n = 1'b1;
    model_clear();
    for (int i = 1; i < DEPTH; i += NR) begin
      for (int p = 0; p < NR; p++)
        ra[p*AW +: AW] = AW'((i + p) % DEPTH);
      cyc(4'b1111, ra, 0, 0, 0, 0, 0);
    end

    // Basic write then read
    cyc(4'b0000, '0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    rd1(5'd5);
    @(posedge clk); #2;
    chk("basic", lane(0), 32'hDEADBEEF);

    // Same-edge conflict on 7
    cyc(4'b0001, {15'd0, 5'd7}, 1, 5'd7, 32'h1234, 0, 0);
    @(posedge clk); #2;
`ifdef REGFILE_BYPASS_EN
    chk("conflict", lane(0), 32'h1234);
`else
    chk("conflict", lane(0), 32'h0);
`endif
    rd1(5'd7);
    @(posedge clk); #2;
    chk("conflict_next", lane(0), 32'h1234);

    // Register zero
    cyc(4'b0000, '0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0);
    rd1(5'd0);
    @(posedge clk); #2;
    chk("zero_data", lane(0), ZR != 0 ? 32'h0 : 32'hFFFFFFFF);
    chk("zero_busy", {31'd0, rd_busy[0]}, ZR != 0 ? 32'd0 : 32'd1);

    // Scoreboard on 3
    cyc(4'b0000, '0, 0, 0, 0, 1, 5'd3);
    rd1(5'd3);
    @(posedge clk); #2;
    chk("sb_set", {31'd0, rd_busy[0]}, 32'd1);
    cyc(4'b0000, '0, 1, 5'd3, 32'h33, 0, 0);
    rd1(5'd3);
    @(posedge clk); #2;
    chk("sb_clr", {31'd0, rd_busy[0]}, 32'd0);
    cyc(4'b0000, '0, 1, 5'd3, 32'h34, 1, 5'd3);
    rd1(5'd3);
    @(posedge clk); #2;
    chk("sb_setwins", {31'd0, rd_busy[0]}, 32'd1);

    // Four ports, then hold
    cyc(4'b0000, '0, 1, 5'd1, 32'hA1, 0, 0);
    cyc(4'b0000, '0, 1, 5'd2, 32'hA2, 0, 0);
    cyc(4'b1111, {5'd1, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("mp0", lane(0), 32'hA1);
    chk("mp1", lane(1), 32'hA2);
    chk("mp2", lane(2), 32'h34);
    chk("mp3", lane(3), 32'hA1);
    for (int i = 1; i < 4; i++)
      cyc(4'b0000, '0, 1, AW'(i), 32'hB0 + i, 0, 0);
    @(posedge clk); #2;
    chk("hold0", lane(0), 32'hA1);
    chk("hold2", lane(2), 32'h34);

    // Random traffic, biased toward a few registers for collisions
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NR; p++)
        ra[p*AW +: AW] = ($urandom_range(0, 1) != 0) ?
                         AW'($urandom_range(0, 3)) : AW'($urandom);
      cyc(NR'($urandom), ra, 1'($urandom),
          AW'($urandom_range(0, 3)), $urandom,
          1'($urandom), AW'($urandom_range(0, 3)));
    end

    cyc(4'b0000, '0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
